// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared FSM states, header bytes and checksum helper for the command frame parser.
package cmd_frame_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_LEN, S_PAYLOAD, S_CSUM, S_REPLAY} state_t;
  localparam logic [7:0] HDR0_BYTE = 8'h55;
  localparam logic [7:0] HDR1_BYTE = 8'hAA;
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
endpackage

// File: rtl/cmd_frame_parser_buf.sv
// cmd_payload_buf: simple dual-port payload RAM, synchronous write, registered read.
module cmd_payload_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  // The read register doubles as the payload output register, so it is reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_rdata <= 8'd0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: finds HDR0/HDR1/LEN/payload/CSUM frames, checks them and replays good payloads.
// Optional inter-byte timeout is enabled with `define CMD_TIMEOUT_EN.
module cmd_frame_parser
  import cmd_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 64,
  parameter logic [7:0] HDR0        = HDR0_BYTE,
  parameter logic [7:0] HDR1        = HDR1_BYTE,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_cmd_per_len,
  output logic [7:0] o_cmd_per_data,
  output logic       o_cmd_per_last,
  output logic       o_cmd_per_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  state_t r_state, w_next;
  logic [7:0] r_len, r_csum, r_len_out;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic w_err, w_ovr, w_we, w_rd_last, w_tmo;
  logic r_valid, r_last, r_err, r_ovr, r_busy;
  assign w_rd_last = 8'(r_rd_ptr) == r_len - 8'd1;
`ifdef CMD_TIMEOUT_EN
  logic [31:0] r_tmo;
  logic w_cnt;
  assign w_cnt = r_state inside {S_HDR1, S_LEN, S_PAYLOAD, S_CSUM};
  assign w_tmo = w_cnt && !i_rx_valid && r_tmo == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_tmo <= 32'd0;
    else r_tmo <= (i_rx_valid || !w_cnt) ? 32'd0 : r_tmo + 32'd1;
  end
`else
  // Without the timeout feature the parser waits forever; a non-negative TIMEOUT_CYC never fires.
  assign w_tmo = (TIMEOUT_CYC < 0);
`endif
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_ovr  = 1'b0;
    w_we   = 1'b0;
    if (w_tmo) begin
      w_next = S_IDLE;
      w_err  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE:    if (i_rx_valid && i_rx_data == HDR0) w_next = S_HDR1;
        S_HDR1:    if (i_rx_valid) w_next = (i_rx_data == HDR1) ? S_LEN : (i_rx_data == HDR0) ? S_HDR1 : S_IDLE;
        S_LEN:     if (i_rx_valid) begin
                     w_err  = i_rx_data == 8'd0 || i_rx_data > 8'(MAX_LEN);
                     w_next = w_err ? S_IDLE : S_PAYLOAD;
                   end
        S_PAYLOAD: if (i_rx_valid) begin
                     w_we = 1'b1;
                     if (8'(r_wr_ptr) == r_len - 8'd1) w_next = S_CSUM;
                   end
        S_CSUM:    if (i_rx_valid) begin
                     w_err  = i_rx_data != r_csum;
                     w_next = w_err ? S_IDLE : S_REPLAY;
                   end
        S_REPLAY:  begin
                     w_ovr = i_rx_valid;
                     if (w_rd_last) w_next = S_IDLE;
                   end
        default:   w_next = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_len     <= 8'd0;
      r_csum    <= 8'd0;
      r_len_out <= 8'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      r_ovr   <= w_ovr;
      r_busy  <= w_next != S_IDLE;
      r_valid <= r_state == S_REPLAY;
      r_last  <= r_state == S_REPLAY && w_rd_last;
      if (r_state == S_LEN && i_rx_valid) begin
        r_len    <= i_rx_data;
        r_csum   <= i_rx_data;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end
      if (w_we) begin
        r_csum   <= csum_add(r_csum, i_rx_data);
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (r_state == S_REPLAY) begin
        r_len_out <= r_len;
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end
  cmd_payload_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_rx_data),
    .i_re    (r_state == S_REPLAY),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_cmd_per_data)
  );
  assign o_cmd_per_len   = r_len_out;
  assign o_cmd_per_last  = r_last;
  assign o_cmd_per_valid = r_valid;
  assign o_frame_err     = r_err;
  assign o_overrun       = r_ovr;
  assign o_busy          = r_busy;
endmodule
